bit_deserializer: RTL and testbench

Downstream consumer of the registered 1-bit mux output stream from the `sequential` stage.
Collects qualified serial bits into WIDTH-bit words and presents them on a valid/ready output port.
Counts and flags bits lost while the output side is stalled.
Sits between the serial select/mux stage and any word-oriented logic.

---
 rtl/bit_deserializer_pkg.sv | 12 +
 rtl/bit_deserializer_sat_counter.sv | 24 ++
 rtl/bit_deserializer.sv | 155 +++++++++++++++
 tb/tb_bit_deserializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared constants and state encoding for the serial-to-word deserializer.
package bit_deserializer_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 8;
  localparam int unsigned DEFAULT_DROP_W = 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/bit_deserializer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc, stop at all-ones; clr returns to zero
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/bit_deserializer.sv
// Collects qualified serial bits into WIDTH-bit words on a valid/ready port,
// parking one completed word while the port is stalled and counting bits
// that arrive while parked.
module bit_deserializer
  import bit_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned DROP_W    = DEFAULT_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              clr,
  output logic [WIDTH-1:0]  out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overflow;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic             w_valid_nxt;
  logic             w_drop;
  logic             w_last;
  logic             w_out_free;
  logic             w_complete;

  assign w_last     = (r_cnt == LAST_CNT);
  assign w_out_free = !r_valid || out_ready;
  assign w_complete = in_valid && w_last && w_out_free;

  // Shift register contents after accepting in_bit in the configured order
  always_comb begin
    if (MSB_FIRST) begin
      w_shifted = {r_sr[WIDTH-2:0], in_bit};
    end else begin
      w_shifted = {in_bit, r_sr[WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: park in HOLD when a word completes against a full output
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (in_valid && w_last && !w_out_free) w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) w_state_nxt = ST_FILL;
    endcase
    if (clr) w_state_nxt = ST_FILL;
  end

  // Next datapath/output values per state; clr flushes everything but drop tracking
  always_comb begin
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_valid_nxt = r_valid;
    w_drop      = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (in_valid) begin
          w_sr_nxt = w_shifted;
          if (w_last) begin
            w_cnt_nxt = '0;
            if (w_out_free) begin
              w_word_nxt  = w_shifted;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        if (!w_complete && r_valid && out_ready) w_valid_nxt = 1'b0;
      end
      ST_HOLD: begin
        w_drop = in_valid;
        if (out_ready) begin
          w_word_nxt  = r_sr;
          w_valid_nxt = 1'b1;
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
    endcase
    if (clr) begin
      w_sr_nxt    = '0;
      w_cnt_nxt   = '0;
      w_word_nxt  = '0;
      w_valid_nxt = 1'b0;
      w_drop      = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Sticky overflow flag, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk (clk),
    .clr (rst),
    .inc (w_drop),
    .cnt (drop_cnt)
  );

  assign out_word  = r_word;
  assign out_valid = r_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench: one MSB-first and one LSB-first instance share stimulus.
module tb_bit_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] word_m, word_l, drop_m, drop_l;
  logic       valid_m, valid_l, ovf_m, ovf_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .DROP_W(8)) u_msb (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .out_word(word_m), .out_valid(valid_m), .out_ready(out_ready),
    .overflow(ovf_m), .drop_cnt(drop_m)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .DROP_W(8)) u_lsb (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .out_word(word_l), .out_valid(valid_l), .out_ready(out_ready),
    .overflow(ovf_l), .drop_cnt(drop_l)
  );

  typedef struct {
    logic       b;
    logic       v;
    logic       rdy;
    logic       r;
    logic       c;
    logic       ev;
    logic [7:0] ew_m;
    logic [7:0] ew_l;
    logic       eo;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic b, v, rdy, r, c, ev,
                              input logic [7:0] ew_m, ew_l,
                              input logic eo, input logic [7:0] ed);
    vec_t x;
    x.b = b; x.v = v; x.rdy = rdy; x.r = r; x.c = c;
    x.ev = ev; x.ew_m = ew_m; x.ew_l = ew_l; x.eo = eo; x.ed = ed;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic b, v, rdy, r, c);
    in_bit = b; in_valid = v; out_ready = rdy; rst = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rdy);
    for (int i = 7; i >= 0; i--) cyc(d[i], 1'b1, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;

    // reset, 1011_0010 with ready high, then back-to-back 0x00 / 0xFF
    add(0,0,1,1,0, 0, 8'h00, 8'h00, 0, 8'd0);
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--)
      add(pat[i],1,1,0,0, (i == 0), (i == 0) ? 8'hB2 : 8'h00, (i == 0) ? 8'h4D : 8'h00, 0, 8'd0);
    add(0,0,1,0,0, 0, 8'hB2, 8'h4D, 0, 8'd0);
    for (int i = 7; i >= 0; i--)
      add(0,1,1,0,0, (i == 0), (i == 0) ? 8'h00 : 8'hB2, (i == 0) ? 8'h00 : 8'h4D, 0, 8'd0);
    for (int i = 7; i >= 0; i--)
      add(1,1,1,0,0, (i == 0), (i == 0) ? 8'hFF : 8'h00, (i == 0) ? 8'hFF : 8'h00, 0, 8'd0);
    add(0,0,1,0,0, 0, 8'hFF, 8'hFF, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].b, vecs[i].v, vecs[i].rdy, vecs[i].r, vecs[i].c);
      chk($sformatf("vec%0d valid_m", i), 8'(valid_m), 8'(vecs[i].ev));
      chk($sformatf("vec%0d valid_l", i), 8'(valid_l), 8'(vecs[i].ev));
      chk($sformatf("vec%0d word_m", i), word_m, vecs[i].ew_m);
      chk($sformatf("vec%0d word_l", i), word_l, vecs[i].ew_l);
      chk($sformatf("vec%0d ovf_m", i), 8'(ovf_m), 8'(vecs[i].eo));
      chk($sformatf("vec%0d drop_m", i), drop_m, vecs[i].ed);
    end

    // stall: 0xA5 fills output, 0x3C parks in HOLD, 3 bits dropped
    send_byte(8'hA5, 1'b0);
    chk("stall first word", word_m, 8'hA5);
    chk("stall first valid", 8'(valid_m), 8'd1);
    send_byte(8'h3C, 1'b0);
    chk("stall held word", word_m, 8'hA5);
    chk("stall no drop yet", drop_m, 8'd0);
    chk("stall no ovf yet", 8'(ovf_m), 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall drop_m", drop_m, 8'd3);
    chk("stall drop_l", drop_l, 8'd3);
    chk("stall ovf", 8'(ovf_m), 8'd1);
    chk("stall word still A5", word_m, 8'hA5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("release word", word_m, 8'h3C);
    chk("release valid", 8'(valid_m), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stable word", word_m, 8'h3C);
    chk("stable valid", 8'(valid_m), 8'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("consume valid", 8'(valid_m), 8'd0);

    // rst mid-word aborts the partial word and clears drop tracking
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst word_m", word_m, 8'h00);
    chk("rst word_l", word_l, 8'h00);
    chk("rst valid", 8'(valid_m), 8'd0);
    chk("rst ovf", 8'(ovf_m), 8'd0);
    chk("rst drop", drop_m, 8'd0);
    send_byte(8'hC3, 1'b1);
    chk("post-rst word_m", word_m, 8'hC3);
    chk("post-rst word_l", word_l, 8'hC3);
    chk("post-rst valid", 8'(valid_m), 8'd1);

    // build up 2 drops, then clr mid-word keeps overflow/drop_cnt
    send_byte(8'h11, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre-clr drop", drop_m, 8'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre-clr release", word_m, 8'h11);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre-clr consumed", 8'(valid_m), 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr word", word_m, 8'h00);
    chk("clr valid", 8'(valid_m), 8'd0);
    chk("clr ovf kept", 8'(ovf_m), 8'd1);
    chk("clr drop kept", drop_m, 8'd2);
    send_byte(8'hC3, 1'b1);
    chk("post-clr word_m", word_m, 8'hC3);
    chk("post-clr word_l", word_l, 8'hC3);
    chk("post-clr drop", drop_m, 8'd2);

    // saturation: park 0x5A in HOLD, then drop 300 bits
    send_byte(8'h5A, 1'b0);
    chk("sat held word", word_m, 8'hC3);
    chk("sat held valid", 8'(valid_m), 8'd1);
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 252) chk("sat drop 254", drop_m, 8'd254);
      if (k == 253) chk("sat drop 255", drop_m, 8'd255);
    end
    chk("sat drop_m", drop_m, 8'd255);
    chk("sat drop_l", drop_l, 8'd255);
    chk("sat ovf", 8'(ovf_m), 8'd1);
    chk("sat word stable", word_m, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("final rst drop", drop_m, 8'd0);
    chk("final rst ovf", 8'(ovf_m), 8'd0);
    chk("final rst valid", 8'(valid_m), 8'd0);
    chk("final rst word", word_m, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
